// File: rtl/delay_line_ram.sv
// Circular sample history on a single-port RAM, shared between the audio push
// path and effect read/write taps addressed relative to the newest sample.
//
// state   | meaning
// IDLE    | pick highest-priority pending request (push > read > write)
// AUD_WR  | write latched sample at wr_ptr+1, advance wr_ptr
// RD_ADDR | present latched read address to the RAM
// RD_DATA | register RAM output into eff_data_out
// EFF_WR  | write latched effect data at latched address
module delay_line_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  sample_ack,
    input  logic                  eff_rd,
    input  logic                  eff_wr,
    input  logic [ADDR_WIDTH-1:0] eff_offset,
    input  logic [DATA_WIDTH-1:0] eff_data_in,
    output logic [DATA_WIDTH-1:0] eff_data_out,
    output logic                  eff_rd_done,
    output logic                  eff_wr_done,
    output logic                  busy,
    output logic                  overflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, AUD_WR, RD_ADDR, RD_DATA, EFF_WR} state_t;
    state_t state;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill;
    logic                  pend_aud;
    logic                  pend_rd;
    logic                  pend_wr;
    logic [DATA_WIDTH-1:0] aud_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_zero;
    logic [ADDR_WIDTH-1:0] cap_addr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    // Effect addresses resolve against wr_ptr as it stands now, before any push in service.
    assign cap_addr = wr_ptr - eff_offset;
    assign busy     = pend_aud | pend_rd | pend_wr | (state != IDLE);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = wr_data;
        case (state)
            AUD_WR: begin
                ram_we    = !rst;
                ram_addr  = wr_ptr + ADDR_WIDTH'(1);
                ram_wdata = aud_data;
            end
            EFF_WR: begin
                ram_we   = !rst;
                ram_addr = wr_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '1;
            fill         <= '0;
            pend_aud     <= 1'b0;
            pend_rd      <= 1'b0;
            pend_wr      <= 1'b0;
            aud_data     <= '0;
            wr_data      <= '0;
            rd_addr      <= '0;
            wr_addr      <= '0;
            rd_zero      <= 1'b0;
            sample_ack   <= 1'b0;
            eff_rd_done  <= 1'b0;
            eff_wr_done  <= 1'b0;
            eff_data_out <= '0;
            overflow     <= 1'b0;
        end else begin
            sample_ack  <= 1'b0;
            eff_rd_done <= 1'b0;
            eff_wr_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend_aud) begin
                        state <= AUD_WR;
                    end else if (pend_rd) begin
                        state <= RD_ADDR;
                    end else if (pend_wr) begin
                        state <= EFF_WR;
                    end
                end
                AUD_WR: begin
                    wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                    if (fill != FILL_MAX) begin
                        fill <= fill + (ADDR_WIDTH + 1)'(1);
                    end
                    pend_aud   <= 1'b0;
                    sample_ack <= 1'b1;
                    state      <= IDLE;
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    eff_data_out <= rd_zero ? '0 : ram_q;
                    pend_rd      <= 1'b0;
                    eff_rd_done  <= 1'b1;
                    state        <= IDLE;
                end
                EFF_WR: begin
                    pend_wr     <= 1'b0;
                    eff_wr_done <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Capture follows service: a set pending flag (even one cleared this edge) drops the newcomer.
            if (sample_valid) begin
                if (pend_aud) begin
                    overflow <= 1'b1;
                end else begin
                    pend_aud <= 1'b1;
                    aud_data <= sample_in;
                end
            end
            if (eff_rd) begin
                if (pend_rd) begin
                    overflow <= 1'b1;
                end else begin
                    pend_rd <= 1'b1;
                    rd_addr <= cap_addr;
                    rd_zero <= ({1'b0, eff_offset} >= fill);
                end
            end
            if (eff_wr) begin
                if (pend_wr) begin
                    overflow <= 1'b1;
                end else begin
                    pend_wr <= 1'b1;
                    wr_addr <= cap_addr;
                    wr_data <= eff_data_in;
                end
            end
        end
    end
endmodule
